// File: rtl/cs_packetizer.sv
// -----------------------------------------------------------------------------
// cs_packetizer
//
// Output stage of the compressive-sensing quantizer. It captures one quantized
// measurement packet together with the quantizer shift used for it. The packet
// is then sent as a serial word stream with a valid/ready handshake: first one
// header word that carries the shift, then REG_BANK_DEPTH payload words (word 0
// first).
//
// Optional feature: define CS_PACKETIZER_CHECKSUM_EN to append one checksum
// word. The checksum is the XOR of the header and all payload words, and
// out_last then marks the checksum word instead of the last payload word.
//
// Ports:
//   clk         rising-edge clock
//   rst         synchronous, active-high reset
//   in_valid    upstream packet present
//   in_ready    packet accepted this cycle (idle and not in reset)
//   bit_shift   quantizer shift for the presented packet
//   bit_stream  packed packet, word i at [DATA_WIDTH*i +: DATA_WIDTH]
//   out_data    current stream word (registered)
//   out_valid   out_data valid
//   out_ready   downstream accepts the current word
//   out_last    current word is the final word of the packet (registered)
//   busy        a packet is held or being streamed
// -----------------------------------------------------------------------------
module cs_packetizer #(
    parameter int DATA_WIDTH      = 16,
    parameter int REG_BANK_DEPTH  = 8,
    parameter int BIT_SHIFT_WIDTH = 4,
    parameter int PACKET_LEN      = DATA_WIDTH * REG_BANK_DEPTH
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [BIT_SHIFT_WIDTH-1:0] bit_shift,
    input  logic [PACKET_LEN-1:0]      bit_stream,
    output logic [DATA_WIDTH-1:0]      out_data,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic                       out_last,
    output logic                       busy
);

    localparam int CNT_W = (REG_BANK_DEPTH > 1) ? $clog2(REG_BANK_DEPTH) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(REG_BANK_DEPTH - 1);

`ifdef CS_PACKETIZER_CHECKSUM_EN
    localparam bit LAST_ON_PAYLOAD = 1'b0;
`else
    localparam bit LAST_ON_PAYLOAD = 1'b1;
`endif

    typedef enum logic [1:0] {
        IDLE,
        HEADER,
`ifdef CS_PACKETIZER_CHECKSUM_EN
        PAYLOAD,
        CHECK
`else
        PAYLOAD
`endif
    } state_t;

    state_t                  state;
    logic [CNT_W-1:0]        cnt;
    logic [CNT_W-1:0]        cnt_next;
    logic [DATA_WIDTH-1:0]   words_q  [REG_BANK_DEPTH];
    logic [DATA_WIDTH-1:0]   in_words [REG_BANK_DEPTH];
    logic [DATA_WIDTH-1:0]   header_word;
    logic                    accept_out;

`ifdef CS_PACKETIZER_CHECKSUM_EN
    logic [DATA_WIDTH-1:0]   chk_in;
    logic [DATA_WIDTH-1:0]   chk_q;
`endif

    assign in_ready   = (state == IDLE) && !rst;
    assign busy       = (state != IDLE);
    assign accept_out = out_valid && out_ready;
    assign cnt_next   = cnt + CNT_W'(1);

    // Unpack the flat input packet into words and zero-extend the shift.
    always_comb begin
        for (int unsigned i = 0; i < REG_BANK_DEPTH; i++) begin
            in_words[i] = bit_stream[DATA_WIDTH*i +: DATA_WIDTH];
        end
        header_word = DATA_WIDTH'(bit_shift);
    end

`ifdef CS_PACKETIZER_CHECKSUM_EN
    // The checksum is computed from the inputs at capture time. Because it is
    // held in chk_q, it cannot change during stalls.
    always_comb begin
        chk_in = header_word;
        for (int unsigned i = 0; i < REG_BANK_DEPTH; i++) begin
            chk_in = chk_in ^ in_words[i];
        end
    end
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            out_valid <= 1'b0;
            out_last  <= 1'b0;
            out_data  <= '0;
            cnt       <= '0;
`ifdef CS_PACKETIZER_CHECKSUM_EN
            chk_q     <= '0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    // in_ready is just (IDLE && !rst), and rst is low here.
                    if (in_valid) begin
                        words_q   <= in_words;
                        state     <= HEADER;
                        out_valid <= 1'b1;
                        out_data  <= header_word;
                        out_last  <= 1'b0;
                        cnt       <= '0;
`ifdef CS_PACKETIZER_CHECKSUM_EN
                        chk_q     <= chk_in;
`endif
                    end
                end

                HEADER: begin
                    if (accept_out) begin
                        state    <= PAYLOAD;
                        cnt      <= '0;
                        out_data <= words_q[0];
                        out_last <= LAST_ON_PAYLOAD && (REG_BANK_DEPTH == 1);
                    end
                end

                PAYLOAD: begin
                    if (accept_out) begin
                        if (cnt == CNT_LAST) begin
                            cnt <= '0;
`ifdef CS_PACKETIZER_CHECKSUM_EN
                            state    <= CHECK;
                            out_data <= chk_q;
                            out_last <= 1'b1;
`else
                            state     <= IDLE;
                            out_valid <= 1'b0;
                            out_last  <= 1'b0;
                            out_data  <= '0;
`endif
                        end else begin
                            // The next word is preloaded into the output
                            // register. This way out_data never depends
                            // combinationally on out_ready.
                            cnt      <= cnt_next;
                            out_data <= words_q[cnt_next];
                            out_last <= LAST_ON_PAYLOAD && (cnt_next == CNT_LAST);
                        end
                    end
                end

`ifdef CS_PACKETIZER_CHECKSUM_EN
                CHECK: begin
                    if (accept_out) begin
                        state     <= IDLE;
                        out_valid <= 1'b0;
                        out_last  <= 1'b0;
                        out_data  <= '0;
                        cnt       <= '0;
                    end
                end
`endif

                default: begin
                    state     <= IDLE;
                    out_valid <= 1'b0;
                    out_last  <= 1'b0;
                    out_data  <= '0;
                    cnt       <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_cs_packetizer.sv
// -----------------------------------------------------------------------------
// tb_cs_packetizer
//
// Self-checking bench for cs_packetizer. A reference model builds the expected
// word list for each packet: the header, then the payload words, then the
// checksum when CS_PACKETIZER_CHECKSUM_EN is defined. Each scenario task drives
// a packet and checks every accepted word, the out_last placement, stall
// stability and the idle/busy flags.
// -----------------------------------------------------------------------------
module tb_cs_packetizer;

    localparam int DW = 16;
    localparam int D  = 8;
    localparam int SW = 4;
    localparam int PL = DW * D;
`ifdef CS_PACKETIZER_CHECKSUM_EN
    localparam int NW = D + 2;
`else
    localparam int NW = D + 1;
`endif

    logic          clk = 1'b0;
    logic          rst;
    logic          in_valid;
    logic          in_ready;
    logic [SW-1:0] bit_shift;
    logic [PL-1:0] bit_stream;
    logic [DW-1:0] out_data;
    logic          out_valid;
    logic          out_ready;
    logic          out_last;
    logic          busy;

    int vectors = 0;
    int errors  = 0;

    logic [DW-1:0] exp_q[$];

    cs_packetizer #(
        .DATA_WIDTH      (DW),
        .REG_BANK_DEPTH  (D),
        .BIT_SHIFT_WIDTH (SW)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .bit_shift  (bit_shift),
        .bit_stream (bit_stream),
        .out_data   (out_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_last   (out_last),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    // Reference model: the list of words the packet must produce, in order.
    task automatic build_expected(input logic [SW-1:0] shift, input logic [PL-1:0] pkt);
        logic [DW-1:0] w;
`ifdef CS_PACKETIZER_CHECKSUM_EN
        logic [DW-1:0] x;
        x = DW'(shift);
`endif
        exp_q.delete();
        exp_q.push_back(DW'(shift));
        for (int i = 0; i < D; i++) begin
            w = pkt[i*DW +: DW];
            exp_q.push_back(w);
`ifdef CS_PACKETIZER_CHECKSUM_EN
            x = x ^ w;
`endif
        end
`ifdef CS_PACKETIZER_CHECKSUM_EN
        exp_q.push_back(x);
`endif
    endtask

    function automatic logic [PL-1:0] random_packet();
        logic [PL-1:0] p;
        for (int i = 0; i < D; i++) p[i*DW +: DW] = DW'($urandom);
        return p;
    endfunction

    // mode 0: out_ready held high; 1: ready pattern 1,0,0,...; 2: random ready.
    // poke_busy: present other input data on in_valid while the stream runs.
    // abort_after: apply rst once that many words have transferred (-1 = never).
    task automatic stream_packet(input logic [SW-1:0] shift, input logic [PL-1:0] pkt,
                                 input int mode, input bit poke_busy, input int abort_after);
        int idx, cyc, limit;
        logic pv, pr, pl, rdy;
        logic [DW-1:0] pd;
        build_expected(shift, pkt);
        limit = (abort_after >= 0) ? abort_after : NW;

        cyc = 0;
        while (in_ready !== 1'b1 && cyc < 20) begin
            @(negedge clk);
            cyc++;
        end
        vectors++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL ready_before_capture: in_ready=%b want 1", in_ready);
        end
        in_valid   = 1'b1;
        bit_shift  = shift;
        bit_stream = pkt;
        out_ready  = 1'b0;
        @(negedge clk);
        in_valid   = poke_busy;
        bit_shift  = SW'($urandom);
        bit_stream = random_packet();

        idx = 0; cyc = 0; pv = 1'b0; pr = 1'b0; pl = 1'b0; pd = '0;
        while (idx < limit && cyc < 300) begin
            vectors++;
            if (out_valid !== 1'b1 || busy !== 1'b1 || in_ready !== 1'b0) begin
                errors++;
                $display("FAIL stream_flags: valid=%b busy=%b in_ready=%b want 1 1 0 (word %0d)",
                         out_valid, busy, in_ready, idx);
            end
            if (pv && !pr) begin
                vectors++;
                if (out_data !== pd || out_last !== pl) begin
                    errors++;
                    $display("FAIL stall_hold: data=%h last=%b want %h %b (word %0d)",
                             out_data, out_last, pd, pl, idx);
                end
            end
            case (mode)
                0:       rdy = 1'b1;
                1:       rdy = (cyc % 3 == 0);
                default: rdy = 1'($urandom_range(0, 1));
            endcase
            out_ready = rdy;
            if (rdy) begin
                vectors++;
                if (out_data !== exp_q[idx] || out_last !== (idx == NW - 1)) begin
                    errors++;
                    $display("FAIL word_%0d: data=%h last=%b want %h %b",
                             idx, out_data, out_last, exp_q[idx], (idx == NW - 1));
                end
                idx++;
            end
            if (poke_busy) begin
                bit_shift  = SW'($urandom);
                bit_stream = random_packet();
                if (idx == NW) in_valid = 1'b0;
            end
            pv = out_valid; pr = rdy; pl = out_last; pd = out_data;
            @(negedge clk);
            cyc++;
        end
        out_ready = 1'b0;
        vectors++;
        if (idx < limit) begin
            errors++;
            $display("FAIL stream_timeout: got %0d words want %0d", idx, limit);
        end

        if (abort_after >= 0) begin
            rst = 1'b1;
            @(negedge clk);
            vectors++;
            if (out_valid !== 1'b0 || busy !== 1'b0 || out_last !== 1'b0 ||
                out_data !== '0 || in_ready !== 1'b0) begin
                errors++;
                $display("FAIL abort_reset: valid=%b busy=%b last=%b data=%h in_ready=%b want 0 0 0 0 0",
                         out_valid, busy, out_last, out_data, in_ready);
            end
            rst = 1'b0;
        end else begin
            vectors++;
            if (out_valid !== 1'b0 || busy !== 1'b0 || in_ready !== 1'b1 || out_last !== 1'b0) begin
                errors++;
                $display("FAIL end_of_packet: valid=%b busy=%b in_ready=%b last=%b want 0 0 1 0",
                         out_valid, busy, in_ready, out_last);
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; in_valid = 1'b1; out_ready = 1'b0;
        bit_shift = 4'h5; bit_stream = random_packet();
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            vectors++;
            if (in_ready !== 1'b0 || out_valid !== 1'b0 || out_data !== '0 ||
                busy !== 1'b0 || out_last !== 1'b0) begin
                errors++;
                $display("FAIL reset_values: in_ready=%b valid=%b data=%h busy=%b last=%b want all 0",
                         in_ready, out_valid, out_data, busy, out_last);
            end
        end
        rst = 1'b0; in_valid = 1'b0;
        #1;
        vectors++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_release: in_ready=%b want 1", in_ready);
        end
        @(negedge clk);
    endtask

    function automatic logic [PL-1:0] counting_packet();
        logic [PL-1:0] p;
        for (int i = 0; i < D; i++) p[i*DW +: DW] = DW'(i + 1);
        return p;
    endfunction

    task automatic test_basic();
        stream_packet(4'd3, counting_packet(), 0, 1'b0, -1);
    endtask

    task automatic test_backpressure();
        stream_packet(4'd3, counting_packet(), 1, 1'b0, -1);
    endtask

    task automatic test_busy_ignore();
        stream_packet(SW'($urandom), random_packet(), 0, 1'b1, -1);
        stream_packet(SW'($urandom), random_packet(), 2, 1'b0, -1);
    endtask

    task automatic test_midstream_reset();
        stream_packet(SW'($urandom), random_packet(), 0, 1'b0, 5);
        stream_packet(4'd3, counting_packet(), 0, 1'b0, -1);
    endtask

    task automatic test_checksum();
        logic [PL-1:0] p;
        p = '0;
        p[0*DW +: DW] = 16'h00F0;
        p[1*DW +: DW] = 16'h0F00;
        p[7*DW +: DW] = 16'h1234;
        stream_packet(4'd2, p, 0, 1'b0, -1);
        stream_packet(4'd2, p, 1, 1'b0, -1);
    endtask

    task automatic test_random();
        for (int n = 0; n < 8; n++) begin
            stream_packet(SW'($urandom), random_packet(), 2, n[0], -1);
        end
        stream_packet(4'hF, {PL{1'b1}}, 0, 1'b0, -1);
        stream_packet(4'h0, '0, 2, 1'b0, -1);
    endtask

    initial begin
        test_reset();
        test_basic();
        test_backpressure();
        test_busy_ignore();
        test_midstream_reset();
        test_checksum();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule

// File: doc/cs_packetizer.md
Name: cs_packetizer

Overview:
Downstream stage of the compressive-sensing quantizer. Captures one quantized measurement packet (`bit_stream`) together with the `bit_shift` used to produce it. Emits the packet as a serial word stream: one header word carrying the shift, then `REG_BANK_DEPTH` payload words. The output uses a valid/ready handshake toward the transmit/storage interface.

Parameters:
- DATA_WIDTH, 16, width of one measurement word and of every output word.
- REG_BANK_DEPTH, 8, number of measurement words per packet.
- BIT_SHIFT_WIDTH, 4, width of the quantizer shift amount; must be <= DATA_WIDTH.
- PACKET_LEN, DATA_WIDTH*REG_BANK_DEPTH, width of the packed input packet (derived; not overridden independently).

Ports:
- clk  input  1  single clock, rising-edge.
- rst  input  1  synchronous reset, active-high.
- in_valid  input  1  upstream packet present.
- in_ready  output  1  block accepts a packet this cycle.
- bit_shift  input  BIT_SHIFT_WIDTH  shift applied by the quantizer to this packet.
- bit_stream  input  PACKET_LEN  quantized packet; word i at bits [DATA_WIDTH*i +: DATA_WIDTH].
- out_data  output  DATA_WIDTH  current stream word.
- out_valid  output  1  out_data valid.
- out_ready  input  1  downstream accepts the word.
- out_last  output  1  current word is the final word of the packet.
- busy  output  1  a packet is held or being streamed.

Behaviour:
- Clock and reset: one clock (`clk`); reset `rst` is synchronous, active-high.
- Reset values: state=IDLE, out_valid=0, out_last=0, out_data=0, word counter=0, busy=0. in_ready=0 while rst is high.
- in_ready = (state==IDLE) && !rst. It is combinational from state and is not affected by out_ready.
- Capture: on in_valid && in_ready at edge N, register `bit_stream` and `bit_shift` and go to HEADER. out_valid=1 from cycle N+1 (latency 1).
- FSM states: IDLE, HEADER, PAYLOAD.
  - IDLE -> HEADER on capture.
  - HEADER: out_data = bit_shift zero-extended to DATA_WIDTH, out_last=0. HEADER -> PAYLOAD on out_valid && out_ready.
  - PAYLOAD: out_data = stored word[cnt], cnt counting 0..REG_BANK_DEPTH-1. Word 0 is emitted first. cnt increments on each accepted word.
  - out_last=1 when cnt==REG_BANK_DEPTH-1. Acceptance of that word -> IDLE, cnt=0, out_valid=0 on the next cycle.
- Handshake rules:
  - A word transfers only on out_valid && out_ready.
  - While out_valid && !out_ready, out_data and out_last hold stable.
  - out_valid never drops before its word transfers.
- Throughput: no bypass from last-word accept to new capture. in_ready rises the cycle after the last transfer, so at most one packet per REG_BANK_DEPTH+2 cycles.
- Input isolation: input changes after capture do not affect the stream; in_valid while busy is ignored and not queued.
- Output registers: out_data and out_last are registered. They are updated on capture and on each accepted word, so no combinational path exists from out_ready to out_data.
- busy = (state!=IDLE).
- Reset mid-stream: the packet is dropped, all outputs return to reset values on the next edge, and no partial out_last is issued.
- Counter: width $clog2(REG_BANK_DEPTH), minimum 1 bit. It never exceeds REG_BANK_DEPTH-1; no wrap occurs inside a packet.

Optional Feature:
- Macro: CS_PACKETIZER_CHECKSUM_EN.
- With the macro defined:
  - Add state CHECK after PAYLOAD.
  - Emit one extra word: the XOR of the header word and all REG_BANK_DEPTH payload words.
  - out_last moves from the final payload word to the checksum word.
  - Packet length is REG_BANK_DEPTH+2 words, and minimum packet period becomes REG_BANK_DEPTH+3 cycles.
  - The checksum is accumulated as words are accepted, or computed at capture; either way it must be stable while stalled.
- Without the macro: no CHECK state, no checksum logic, and out_last is on payload word REG_BANK_DEPTH-1.

Test Plan:
- Reset values: assert rst 3 cycles with in_valid=1 -> in_ready=0, out_valid=0, out_data=0, busy=0. After release, in_ready=1.
- Basic stream: bit_shift=3, words 0x0001..0x0008, out_ready=1 held -> 9 words 0x0003,0x0001,...,0x0008 on consecutive cycles. out_last only on 0x0008. in_ready returns 1 the cycle after.
- Backpressure: same packet, out_ready toggling 1,0,0,1,... -> out_data and out_last unchanged during stalls. Exact 9-word sequence, no duplicates or drops.
- Busy/ignore: second in_valid with different data while streaming -> ignored. First packet is emitted intact. Second is captured only when it is presented again after in_ready=1.
- Mid-stream reset: rst asserted after word 4 is accepted -> next cycle out_valid=0, busy=0. A following packet streams correctly from its header.
- Checksum (macro defined): bit_shift=2, words 0x00F0,0x0F00,0,0,0,0,0,0x1234 -> 10th word = 0x0002^0x00F0^0x0F00^0x1234 = 0x1DC6 with out_last=1. The 9th word has out_last=0.
